// File: rtl/dat_ctrl_pkg.sv
// Shared state encoding, error codes and default widths for the SD host DAT sequencer.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package dat_ctrl_pkg;

    localparam int BLOCKS_W_DEF  = 8;
    localparam int TIMEOUT_W_DEF = 16;
    localparam int WORD_CNT_W    = 5;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_SEND,
        ST_WR_CRC,
        ST_WR_BUSY,
        ST_RD_WAIT,
        ST_RD_RECV,
        ST_RD_CRC,
        ST_DONE,
        ST_ERROR
    } state_t;

    localparam logic [1:0] ERR_NONE      = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT   = 2'd1;
    localparam logic [1:0] ERR_CRC       = 2'd2;
    localparam logic [1:0] ERR_OVR_ABORT = 2'd3;

    // A block size field of zero encodes the maximum of 16 words.
    function automatic logic [WORD_CNT_W-1:0] words_per_block(input logic [3:0] size);
        return (size == 4'd0) ? 5'd16 : {1'b0, size};
    endfunction

endpackage

// File: rtl/dat_transfer_sequencer_if.sv
// Host request, host FIFO and DAT physical-layer signals of the transfer sequencer.
// Latency: none (wires only).
// Backpressure: fifo_empty stalls pops; fifo_full during a received word is an overrun.
interface dat_transfer_sequencer_if
    import dat_ctrl_pkg::*;
#(
    parameter int BLOCKS_W  = BLOCKS_W_DEF,
    parameter int TIMEOUT_W = TIMEOUT_W_DEF
);
    logic                 newService;
    logic                 writeRead;
    logic                 multiblock;
    logic [BLOCKS_W-1:0]  blockCount;
    logic [3:0]           blockSize;
    logic                 timeoutenable;
    logic [TIMEOUT_W-1:0] timeout;
    logic                 abort;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 pop;
    logic                 push;
    logic                 phy_tx_start;
    logic                 phy_rx_start;
    logic                 phy_word_req;
    logic                 phy_word_valid;
    logic                 phy_crc_valid;
    logic                 phy_crc_ok;
    logic                 phy_busy_release;
    logic                 busy;
    logic                 transfer_done;
    logic                 transfer_error;
    logic [1:0]           error_code;

    modport master (
        output newService, writeRead, multiblock, blockCount, blockSize,
               timeoutenable, timeout, abort, fifo_empty, fifo_full,
               phy_word_req, phy_word_valid, phy_crc_valid, phy_crc_ok, phy_busy_release,
        input  pop, push, phy_tx_start, phy_rx_start,
               busy, transfer_done, transfer_error, error_code
    );

    modport slave (
        input  newService, writeRead, multiblock, blockCount, blockSize,
               timeoutenable, timeout, abort, fifo_empty, fifo_full,
               phy_word_req, phy_word_valid, phy_crc_valid, phy_crc_ok, phy_busy_release,
        output pop, push, phy_tx_start, phy_rx_start,
               busy, transfer_done, transfer_error, error_code
    );

endinterface

// File: rtl/dat_timeout_counter.sv
// Cycle counter for the busy-release and start-bit waits; flags expiry against a limit.
// Latency: expired is combinational from the registered count (count == limit in the same cycle).
// Backpressure: none; held at zero while clear is asserted.
module dat_timeout_counter #(
    parameter int TIMEOUT_W = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 run,
    input  logic [TIMEOUT_W-1:0] limit,
    input  logic                 enable,
    output logic                 expired
);
    logic [TIMEOUT_W-1:0] count;

    // Count waiting cycles; saturate so a long wait never wraps back to a small value.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = enable & run & (count == limit);

endmodule

// File: rtl/dat_transfer_sequencer.sv
// SD host DAT path sequencer: runs write/read transfers block by block and reports done/error.
// Latency: busy and phy start pulse one cycle after newService; pop combinational; push one cycle after a word.
// Backpressure: empty host FIFO stalls write pops; full host FIFO on a received word aborts with overrun.
module dat_transfer_sequencer
    import dat_ctrl_pkg::*;
#(
    parameter int BLOCKS_W  = BLOCKS_W_DEF,
    parameter int TIMEOUT_W = TIMEOUT_W_DEF
) (
    input  logic                    clock,
    input  logic                    reset,
    dat_transfer_sequencer_if.slave io
);
    state_t                state;
    logic [BLOCKS_W-1:0]   blocks_left;
    logic [WORD_CNT_W-1:0] words_per_blk;
    logic [WORD_CNT_W-1:0] word_cnt;
    logic [TIMEOUT_W-1:0]  to_limit;
    logic                  to_en;
    logic                  waiting;
    logic                  expired;
    logic                  last_word;
    logic                  last_block;
    logic                  abort_hit;

    assign waiting    = (state == ST_WR_BUSY) || (state == ST_RD_WAIT);
    assign last_word  = (word_cnt <= WORD_CNT_W'(1));
    assign last_block = (blocks_left <= BLOCKS_W'(1));
    // DONE and ERROR are one-cycle reporting states already heading to IDLE.
    assign abort_hit  = io.abort && (state != ST_IDLE) && (state != ST_DONE) && (state != ST_ERROR);

    // The counter is held at zero outside the two wait states, so each entry starts from zero.
    dat_timeout_counter #(.TIMEOUT_W(TIMEOUT_W)) u_timeout (
        .clock   (clock),
        .reset   (reset),
        .clear   (!waiting),
        .run     (waiting),
        .limit   (to_limit),
        .enable  (to_en),
        .expired (expired)
    );

    // Word is taken from the host FIFO in the very cycle the TX converter asks for it.
    assign io.pop = (state == ST_WR_SEND) & io.phy_word_req & ~io.fifo_empty & ~io.abort;

    // Transfer FSM with registered pulses; abort outranks every other event.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state             <= ST_IDLE;
            blocks_left       <= '0;
            words_per_blk     <= '0;
            word_cnt          <= '0;
            to_limit          <= '0;
            to_en             <= 1'b0;
            io.push           <= 1'b0;
            io.phy_tx_start   <= 1'b0;
            io.phy_rx_start   <= 1'b0;
            io.busy           <= 1'b0;
            io.transfer_done  <= 1'b0;
            io.transfer_error <= 1'b0;
            io.error_code     <= ERR_NONE;
        end else begin
            io.push           <= 1'b0;
            io.phy_tx_start   <= 1'b0;
            io.phy_rx_start   <= 1'b0;
            io.transfer_done  <= 1'b0;
            io.transfer_error <= 1'b0;
            if (abort_hit) begin
                state             <= ST_ERROR;
                io.error_code     <= ERR_OVR_ABORT;
                io.transfer_error <= 1'b1;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (io.newService) begin
                            blocks_left   <= (io.multiblock && (io.blockCount != '0)) ? io.blockCount : BLOCKS_W'(1);
                            words_per_blk <= words_per_block(io.blockSize);
                            word_cnt      <= words_per_block(io.blockSize);
                            to_limit      <= io.timeout;
                            to_en         <= io.timeoutenable;
                            io.error_code <= ERR_NONE;
                            io.busy       <= 1'b1;
                            if (io.writeRead) begin
                                state           <= ST_WR_SEND;
                                io.phy_tx_start <= 1'b1;
                            end else begin
                                state           <= ST_RD_WAIT;
                                io.phy_rx_start <= 1'b1;
                            end
                        end
                    end
                    ST_WR_SEND: begin
                        if (io.pop) begin
                            word_cnt <= word_cnt - 1'b1;
                            if (last_word) state <= ST_WR_CRC;
                        end
                    end
                    ST_WR_CRC: begin
                        if (io.phy_crc_valid) begin
                            if (io.phy_crc_ok) begin
                                state <= ST_WR_BUSY;
                            end else begin
                                state             <= ST_ERROR;
                                io.error_code     <= ERR_CRC;
                                io.transfer_error <= 1'b1;
                            end
                        end
                    end
                    ST_WR_BUSY: begin
                        // A release arriving in the expiry cycle still counts as success.
                        if (io.phy_busy_release) begin
                            blocks_left <= blocks_left - 1'b1;
                            if (last_block) begin
                                state            <= ST_DONE;
                                io.transfer_done <= 1'b1;
                            end else begin
                                state           <= ST_WR_SEND;
                                word_cnt        <= words_per_blk;
                                io.phy_tx_start <= 1'b1;
                            end
                        end else if (expired) begin
                            state             <= ST_ERROR;
                            io.error_code     <= ERR_TIMEOUT;
                            io.transfer_error <= 1'b1;
                        end
                    end
                    ST_RD_WAIT, ST_RD_RECV: begin
                        // The first word of a block is handled exactly like the rest.
                        if (io.phy_word_valid) begin
                            if (io.fifo_full) begin
                                state             <= ST_ERROR;
                                io.error_code     <= ERR_OVR_ABORT;
                                io.transfer_error <= 1'b1;
                            end else begin
                                io.push  <= 1'b1;
                                word_cnt <= word_cnt - 1'b1;
                                state    <= last_word ? ST_RD_CRC : ST_RD_RECV;
                            end
                        end else if (expired) begin
                            state             <= ST_ERROR;
                            io.error_code     <= ERR_TIMEOUT;
                            io.transfer_error <= 1'b1;
                        end
                    end
                    ST_RD_CRC: begin
                        if (io.phy_crc_valid) begin
                            if (!io.phy_crc_ok) begin
                                state             <= ST_ERROR;
                                io.error_code     <= ERR_CRC;
                                io.transfer_error <= 1'b1;
                            end else begin
                                blocks_left <= blocks_left - 1'b1;
                                if (last_block) begin
                                    state            <= ST_DONE;
                                    io.transfer_done <= 1'b1;
                                end else begin
                                    state           <= ST_RD_WAIT;
                                    word_cnt        <= words_per_blk;
                                    io.phy_rx_start <= 1'b1;
                                end
                            end
                        end
                    end
                    ST_DONE, ST_ERROR: begin
                        state   <= ST_IDLE;
                        io.busy <= 1'b0;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dat_transfer_sequencer.sv
// Bench for dat_transfer_sequencer: table of whole transfers plus directed timing sequences.
// Latency: inputs driven 1ns after the rising edge, outputs sampled there or at the falling edge.
// Backpressure: the bench plays both host FIFO and DAT physical layer.
module tb_dat_transfer_sequencer;
    import dat_ctrl_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    dat_transfer_sequencer_if #(.BLOCKS_W(8), .TIMEOUT_W(16)) io ();

    dat_transfer_sequencer #(.BLOCKS_W(8), .TIMEOUT_W(16)) dut (
        .clock (clock),
        .reset (reset),
        .io    (io)
    );

    int checks = 0;
    int errors = 0;

    // Running totals of every strobe, counted mid-cycle while out of reset.
    int tot_pop = 0, tot_push = 0, tot_tx = 0, tot_rx = 0, tot_done = 0, tot_err = 0;
    always @(negedge clock) begin
        if (!reset) begin
            tot_pop  += (io.pop === 1'b1) ? 1 : 0;
            tot_push += (io.push === 1'b1) ? 1 : 0;
            tot_tx   += (io.phy_tx_start === 1'b1) ? 1 : 0;
            tot_rx   += (io.phy_rx_start === 1'b1) ? 1 : 0;
            tot_done += (io.transfer_done === 1'b1) ? 1 : 0;
            tot_err  += (io.transfer_error === 1'b1) ? 1 : 0;
        end
    end

    typedef struct {
        bit          wr;
        bit          mb;
        logic [7:0]  bc;
        logic [3:0]  bs;
        bit          ten;
        logic [15:0] tmo;
        int          bad_blk;    // block index answered with a bad CRC, -1 for none
        int          full_word;  // received word index seen with fifo_full, -1 for none
        int          rel_dly;    // cycles spent in WR_BUSY before the card releases DAT0
        bit          stall;      // toggle fifo_empty while words are requested
        int          e_pop;
        int          e_push;
        int          e_tx;
        int          e_rx;
        bit          e_done;
        bit          e_err;
        logic [1:0]  e_code;
    } vec_t;

    localparam int NV = 8;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        io.newService = 1'b0; io.writeRead = 1'b0; io.multiblock = 1'b0;
        io.blockCount = '0; io.blockSize = '0; io.timeoutenable = 1'b0; io.timeout = '0;
        io.abort = 1'b0; io.fifo_empty = 1'b0; io.fifo_full = 1'b0;
        io.phy_word_req = 1'b0; io.phy_word_valid = 1'b0; io.phy_crc_valid = 1'b0;
        io.phy_crc_ok = 1'b0; io.phy_busy_release = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (2) cyc();
        reset = 1'b0;
        cyc();
    endtask

    // Request is held for one cycle; returns one cycle later, in the first cycle of the transfer.
    task automatic start_req(input bit wr, input bit mb, input logic [7:0] bc, input logic [3:0] bs,
                             input bit ten, input logic [15:0] tmo);
        io.writeRead = wr; io.multiblock = mb; io.blockCount = bc; io.blockSize = bs;
        io.timeoutenable = ten; io.timeout = tmo; io.newService = 1'b1;
        cyc();
        io.newService = 1'b0;
    endtask

    task automatic wait_end(input int d0, input int e0);
        int g = 0;
        while (tot_done == d0 && tot_err == e0 && g < 60) begin
            cyc();
            g++;
        end
        repeat (3) cyc();
    endtask

    task automatic run_txn(input vec_t v, input int idx);
        int p0 = tot_pop, u0 = tot_push, t0 = tot_tx, r0 = tot_rx, d0 = tot_done, e0 = tot_err;
        int words = (v.bs == 4'd0) ? 16 : int'(v.bs);
        int nblk  = (v.mb && v.bc != 8'd0) ? int'(v.bc) : 1;
        bit stop  = 1'b0;
        start_req(v.wr, v.mb, v.bc, v.bs, v.ten, v.tmo);
        for (int b = 0; b < nblk && !stop; b++) begin
            if (v.wr) begin
                int g = 0;
                io.phy_word_req = 1'b1;
                while (tot_pop - p0 < (b + 1) * words && g < 200) begin
                    io.fifo_empty = v.stall ? ~io.fifo_empty : 1'b0;
                    cyc();
                    g++;
                end
                io.phy_word_req = 1'b0; io.fifo_empty = 1'b0;
                io.phy_crc_ok = (b != v.bad_blk); io.phy_crc_valid = 1'b1;
                cyc();
                io.phy_crc_valid = 1'b0;
                if (b == v.bad_blk) begin
                    stop = 1'b1;
                end else begin
                    repeat (v.rel_dly - 1) cyc();
                    io.phy_busy_release = 1'b1;
                    cyc();
                    io.phy_busy_release = 1'b0;
                end
            end else begin
                cyc();
                for (int i = 0; i < words && !stop; i++) begin
                    io.phy_word_valid = 1'b1;
                    io.fifo_full = ((b * words + i) == v.full_word);
                    cyc();
                    io.phy_word_valid = 1'b0; io.fifo_full = 1'b0;
                    if ((b * words + i) == v.full_word) stop = 1'b1;
                    else cyc();
                end
                if (!stop) begin
                    io.phy_crc_ok = (b != v.bad_blk); io.phy_crc_valid = 1'b1;
                    cyc();
                    io.phy_crc_valid = 1'b0;
                    if (b == v.bad_blk) stop = 1'b1;
                end
            end
        end
        wait_end(d0, e0);
        chk($sformatf("v%0d pops", idx), tot_pop - p0, v.e_pop);
        chk($sformatf("v%0d pushes", idx), tot_push - u0, v.e_push);
        chk($sformatf("v%0d tx_starts", idx), tot_tx - t0, v.e_tx);
        chk($sformatf("v%0d rx_starts", idx), tot_rx - r0, v.e_rx);
        chk($sformatf("v%0d done", idx), tot_done - d0, v.e_done);
        chk($sformatf("v%0d error", idx), tot_err - e0, v.e_err);
        chk($sformatf("v%0d error_code", idx), io.error_code, v.e_code);
        chk($sformatf("v%0d busy_after", idx), io.busy, 0);
    endtask

    // Single write block up to the cycle the card enters WR_BUSY.
    task automatic write_to_busy(input bit ten, input logic [15:0] tmo);
        start_req(1'b1, 1'b0, 8'd0, 4'd1, ten, tmo);
        io.phy_word_req = 1'b1;
        cyc();
        io.phy_word_req = 1'b0; io.phy_crc_ok = 1'b1; io.phy_crc_valid = 1'b1;
        cyc();
        io.phy_crc_valid = 1'b0;
    endtask

    task automatic count_to_error(output int cnt);
        cnt = 0;
        while (io.transfer_error !== 1'b1 && cnt < 120) begin
            cyc();
            cnt++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cnt, d0, e0, u0;
        //           wr    mb    bc     bs    ten   tmo     bad full rel stall pop push tx rx done  err   code
        vecs[0] = '{1'b1, 1'b0, 8'd0, 4'd1, 1'b0, 16'd0,  -1, -1, 20, 1'b0, 1,  0,   1, 0, 1'b1, 1'b0, ERR_NONE};
        vecs[1] = '{1'b0, 1'b1, 8'd3, 4'd4, 1'b0, 16'd0,  -1, -1, 0,  1'b0, 0,  12,  0, 3, 1'b1, 1'b0, ERR_NONE};
        vecs[2] = '{1'b1, 1'b1, 8'd4, 4'd3, 1'b0, 16'd0,  1,  -1, 3,  1'b0, 6,  0,   2, 0, 1'b0, 1'b1, ERR_CRC};
        vecs[3] = '{1'b0, 1'b0, 8'd1, 4'd4, 1'b0, 16'd0,  -1, 1,  0,  1'b0, 0,  1,   0, 1, 1'b0, 1'b1, ERR_OVR_ABORT};
        vecs[4] = '{1'b1, 1'b0, 8'd5, 4'd0, 1'b0, 16'd0,  -1, -1, 2,  1'b0, 16, 0,   1, 0, 1'b1, 1'b0, ERR_NONE};
        vecs[5] = '{1'b0, 1'b1, 8'd0, 4'd2, 1'b0, 16'd0,  -1, -1, 0,  1'b0, 0,  2,   0, 1, 1'b1, 1'b0, ERR_NONE};
        vecs[6] = '{1'b1, 1'b1, 8'd2, 4'd2, 1'b1, 16'd30, -1, -1, 10, 1'b1, 4,  0,   2, 0, 1'b1, 1'b0, ERR_NONE};
        vecs[7] = '{1'b0, 1'b0, 8'd0, 4'd1, 1'b0, 16'd0,  0,  -1, 0,  1'b0, 0,  1,   0, 1, 1'b0, 1'b1, ERR_CRC};

        // Reset state.
        do_reset();
        chk("rst busy", io.busy, 0);
        chk("rst pop", io.pop, 0);
        chk("rst push", io.push, 0);
        chk("rst tx_start", io.phy_tx_start, 0);
        chk("rst rx_start", io.phy_rx_start, 0);
        chk("rst done", io.transfer_done, 0);
        chk("rst error", io.transfer_error, 0);
        chk("rst error_code", io.error_code, ERR_NONE);

        for (int i = 0; i < NV; i++) begin
            do_reset();
            run_txn(vecs[i], i);
        end

        // Request latency, then busy timeout of 50: expiry in WR_BUSY cycle 50, pulse registered one later.
        do_reset();
        start_req(1'b1, 1'b0, 8'd0, 4'd1, 1'b1, 16'd50);
        chk("req busy", io.busy, 1);
        chk("req tx_start", io.phy_tx_start, 1);
        io.phy_word_req = 1'b1;
        cyc();
        io.phy_word_req = 1'b0; io.phy_crc_ok = 1'b1; io.phy_crc_valid = 1'b1;
        cyc();
        io.phy_crc_valid = 1'b0;
        count_to_error(cnt);
        chk("tmo50 latency", cnt, 51);
        chk("tmo50 error_code", io.error_code, ERR_TIMEOUT);
        cyc();
        chk("tmo50 busy_low", io.busy, 0);

        // Timeout of zero errors one cycle after entering WR_BUSY.
        do_reset();
        write_to_busy(1'b1, 16'd0);
        count_to_error(cnt);
        chk("tmo0 latency", cnt, 1);
        chk("tmo0 error_code", io.error_code, ERR_TIMEOUT);

        // Release landing in the expiry cycle wins.
        do_reset();
        d0 = tot_done; e0 = tot_err;
        write_to_busy(1'b1, 16'd5);
        repeat (5) cyc();
        io.phy_busy_release = 1'b1;
        cyc();
        io.phy_busy_release = 1'b0;
        wait_end(d0, e0);
        chk("race done", tot_done - d0, 1);
        chk("race error", tot_err - e0, 0);
        chk("race error_code", io.error_code, ERR_NONE);

        // Start-bit timeout of 3 while waiting for the first read word.
        do_reset();
        start_req(1'b0, 1'b0, 8'd0, 4'd4, 1'b1, 16'd3);
        count_to_error(cnt);
        chk("rdtmo latency", cnt, 4);
        chk("rdtmo error_code", io.error_code, ERR_TIMEOUT);

        // FIFO full at the second received word: no push, error pulse, busy low two cycles later.
        do_reset();
        u0 = tot_push;
        start_req(1'b0, 1'b0, 8'd0, 4'd4, 1'b0, 16'd0);
        cyc();
        io.phy_word_valid = 1'b1;
        cyc();
        io.phy_word_valid = 1'b0;
        cyc();
        io.phy_word_valid = 1'b1; io.fifo_full = 1'b1;
        cyc();
        io.phy_word_valid = 1'b0; io.fifo_full = 1'b0;
        chk("full error_pulse", io.transfer_error, 1);
        chk("full error_code", io.error_code, ERR_OVR_ABORT);
        chk("full busy_plus1", io.busy, 1);
        cyc();
        chk("full busy_plus2", io.busy, 0);
        chk("full pushes", tot_push - u0, 1);

        // Abort in RD_RECV after two words.
        do_reset();
        u0 = tot_push;
        start_req(1'b0, 1'b0, 8'd0, 4'd4, 1'b0, 16'd0);
        for (int i = 0; i < 2; i++) begin
            cyc();
            io.phy_word_valid = 1'b1;
            cyc();
            io.phy_word_valid = 1'b0;
        end
        io.abort = 1'b1;
        cyc();
        io.abort = 1'b0;
        chk("abort error_pulse", io.transfer_error, 1);
        chk("abort error_code", io.error_code, ERR_OVR_ABORT);
        cyc();
        chk("abort busy_low", io.busy, 0);
        chk("abort pushes", tot_push - u0, 2);

        // Reset in the middle of a read clears everything at once and reports nothing.
        do_reset();
        d0 = tot_done; e0 = tot_err;
        start_req(1'b0, 1'b0, 8'd0, 4'd4, 1'b0, 16'd0);
        cyc();
        io.phy_word_valid = 1'b1;
        cyc();
        io.phy_word_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("midrst busy", io.busy, 0);
        chk("midrst push", io.push, 0);
        chk("midrst rx_start", io.phy_rx_start, 0);
        chk("midrst error_code", io.error_code, ERR_NONE);
        repeat (2) cyc();
        reset = 1'b0;
        repeat (5) cyc();
        chk("midrst done", tot_done - d0, 0);
        chk("midrst error", tot_err - e0, 0);
        chk("midrst busy_after", io.busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
